ram_bank: RTL and testbench
===========================

// Module: ram_bank
// PURPOSE
//  Parametrised word-addressed RAM built from clocked storage; successor to the single-bit dff.
//  Generalises to WIDTH-bit words x 2**ADDR_WIDTH entries with a per-write load enable.
//  Adds a hardware clear sweep after reset, so contents are defined without a reset on every cell.
//  Sits under the CPU data/instruction memory map as the generic RAM primitive.
// PARAMETERS
//  WIDTH       16  data word width in bits
//  ADDR_WIDTH  3   address width; DEPTH = 2**ADDR_WIDTH words
// PORTS
//  clock    in   1           system clock; all state updates on posedge
//  reset_n  in   1           asynchronous, active-low reset
//  in       in   WIDTH       write data
//  load     in   1           write enable, sampled on posedge
//  address  in   ADDR_WIDTH  read/write address
//  out      out  WIDTH       read data
//  ready    out  1           1 = clear sweep finished; reads and writes honoured
// BEHAVIOUR
//  Reset (reset_n=0, async): state=CLEAR, clear_ptr=0, ready=0, out=0. Array contents not reset directly.
//  FSM states: CLEAR -> READY only.
//   CLEAR: each posedge writes 0 to mem[clear_ptr], clear_ptr++. On the posedge writing
//          mem[DEPTH-1], go to READY; ready=1 from that edge. Sweep lasts exactly DEPTH cycles.
//          load/in/address ignored; out held at 0.
//   READY: on posedge with load=1, mem[address] <= in. load=0 leaves memory unchanged.
//          Stays in READY until reset_n asserted.
//  clear_ptr is ADDR_WIDTH bits wide; the terminal test is clear_ptr == DEPTH-1, not overflow.
//  Read (READY, default build): out = mem[address], combinational, 0-cycle latency.
//   Write to the addressed word: out shows old value until the edge, new value right after it.
//  Address change with load=0: out tracks the new word combinationally; no state change.
//  Reset mid-sweep or mid-write: async abort; state=CLEAR, clear_ptr=0; sweep restarts in full.
//   A write coinciding with reset assertion has undefined effect; the sweep overwrites it.
//  Widths: in/out exactly WIDTH bits; no truncation or extension inside the block.
// CONFIGURATION
//  RAM_REGISTERED_OUT_EN defined: out is a register (iCE40 BRAM-friendly).
//   READY: out <= mem[address] on each posedge; 1-cycle read latency.
//   Same-address write: read-first; out gets the pre-write value, new value one edge later.
//   out register reset to 0 async; held at 0 through CLEAR.
//  RAM_REGISTERED_OUT_EN not defined: combinational read as above. Write timing is identical.
// STRUCTURE
//  Shared package hack_mem_pkg:
//   - state encoding localparams ST_CLEAR=1'b0, ST_READY=1'b1
//   - default WIDTH/ADDR_WIDTH constants reused by other memory blocks
//  Sub-module ram_clear_seq: owns the FSM and clear_ptr.
//   - outputs clear_we, clear_addr, ready.
//   - ram_bank muxes write port: (clear_we ? {clear_addr,0} : {address,in}).
//  Storage: reg [WIDTH-1:0] mem [0:DEPTH-1], one write port and one read port.
// TESTING (WIDTH=16, ADDR_WIDTH=3, clock 10ns period)
//  1. Release reset_n -> ready=0 for 8 posedges, ready=1 after 8th; read all 8 addrs -> 0x0000.
//  2. READY, load=1, address=5, in=0xBEEF, one edge; then load=0
//     -> out=0xBEEF at addr 5 (next cycle if REGISTERED); addr 4 -> 0x0000.
//  3. During CLEAR, load=1, address=2, in=0x1234 -> ignored; after ready, addr 2 reads 0x0000.
//  4. Write 0xAAAA to addr 7 and 0x5555 to addr 0 -> both read back.
//     Confirms ADDR_WIDTH boundary with no aliasing.
//  5. Sweep cycle 4: pulse reset_n=0 for 3ns -> out=0, ready=0 immediately.
//     Sweep restarts; ready rises exactly 8 edges after release.
//  6. REGISTERED build, addr 3=0x0011: load=1, in=0x0022 at addr 3
//     -> out=0x0011 after that edge, 0x0022 after the next.
//     Default build -> out=0x0022 immediately after the write edge.

Source files
------------

// File: rtl/hack_mem_pkg.sv
// Shared definitions for the generic memory primitives: default geometry and the
// clear-sequencer state encoding.
package hack_mem_pkg;

   localparam int DEFAULT_WIDTH      = 16;
   localparam int DEFAULT_ADDR_WIDTH = 3;

   typedef enum logic {
      ST_CLEAR = 1'b0,
      ST_READY = 1'b1
   } ram_state_t;

endpackage

// File: rtl/ram_clear_seq.sv
// Post-reset clear sequencer: walks every address once writing zero, then raises ready.
//
// state    | meaning
// ST_CLEAR | sweeping, one word per posedge; user port ignored
// ST_READY | sweep done, user reads/writes honoured until next reset
module ram_clear_seq
   import hack_mem_pkg::*;
#(
   parameter int ADDR_WIDTH = DEFAULT_ADDR_WIDTH
) (
   input  logic                  clock,
   input  logic                  reset_n,
   output logic                  clear_we,
   output logic [ADDR_WIDTH-1:0] clear_addr,
   output logic                  ready
);

   localparam logic [ADDR_WIDTH-1:0] LAST_ADDR = '1;

   ram_state_t            state;
   logic [ADDR_WIDTH-1:0] clear_ptr;

   always_ff @(posedge clock or negedge reset_n) begin
      if (!reset_n) begin
         state     <= ST_CLEAR;
         clear_ptr <= '0;
         ready     <= 1'b0;
      end else if (state == ST_CLEAR) begin
         clear_ptr <= clear_ptr + ADDR_WIDTH'(1);
         // Terminal compare on the last word, so the sweep is exactly DEPTH edges long.
         if (clear_ptr == LAST_ADDR) begin
            state <= ST_READY;
            ready <= 1'b1;
         end
      end
   end

   assign clear_we   = (state == ST_CLEAR);
   assign clear_addr = clear_ptr;

endmodule

// File: rtl/ram_bank.sv
// Word-addressed RAM with hardware clear sweep after reset. Define RAM_REGISTERED_OUT_EN
// for a registered (read-first, 1-cycle latency) read port; default is combinational read.
module ram_bank
   import hack_mem_pkg::*;
#(
   parameter int WIDTH      = DEFAULT_WIDTH,
   parameter int ADDR_WIDTH = DEFAULT_ADDR_WIDTH
) (
   input  logic                  clock,
   input  logic                  reset_n,
   input  logic [WIDTH-1:0]      in,
   input  logic                  load,
   input  logic [ADDR_WIDTH-1:0] address,
   output logic [WIDTH-1:0]      out,
   output logic                  ready
);

   localparam int DEPTH = 2 ** ADDR_WIDTH;

   logic [WIDTH-1:0]      mem [0:DEPTH-1];
   logic                  clear_we;
   logic [ADDR_WIDTH-1:0] clear_addr;
   logic                  wr_en;
   logic [ADDR_WIDTH-1:0] wr_addr;
   logic [WIDTH-1:0]      wr_data;

   ram_clear_seq #(.ADDR_WIDTH(ADDR_WIDTH)) u_clear_seq (
      .clock      (clock),
      .reset_n    (reset_n),
      .clear_we   (clear_we),
      .clear_addr (clear_addr),
      .ready      (ready)
   );

   // The sweep owns the write port until ready; user load is only honoured afterwards.
   assign wr_en   = clear_we | (ready & load);
   assign wr_addr = clear_we ? clear_addr : address;
   assign wr_data = clear_we ? '0 : in;

   always_ff @(posedge clock) begin
      if (wr_en) begin
         mem[wr_addr] <= wr_data;
      end
   end

`ifdef RAM_REGISTERED_OUT_EN
   always_ff @(posedge clock or negedge reset_n) begin
      if (!reset_n) begin
         out <= '0;
      end else if (ready) begin
         out <= mem[address];
      end else begin
         out <= '0;
      end
   end
`else
   assign out = ready ? mem[address] : '0;
`endif

endmodule

// File: tb/tb_ram_bank.sv
// Self-checking bench for ram_bank against an array reference model; covers both read-port builds.
module tb_ram_bank;

   logic        clock;
   logic        reset_n;
   logic [15:0] din;
   logic        load;
   logic [2:0]  address;
   logic [15:0] dout;
   logic        ready;

   logic [15:0] model_mem [0:7];
   int          checks;
   int          passed;

   ram_bank #(.WIDTH(16), .ADDR_WIDTH(3)) dut (
      .clock   (clock),
      .reset_n (reset_n),
      .in      (din),
      .load    (load),
      .address (address),
      .out     (dout),
      .ready   (ready)
   );

   initial clock = 1'b0;
   always #5 clock = ~clock;

   initial begin
      #100000;
      $display("FAIL watchdog: simulation time limit reached, actual running required finished");
      $fatal(1);
   end

   task automatic model_clear();
      for (int i = 0; i < 8; i++) model_mem[i] = 16'h0000;
   endtask

   task automatic write_word(input logic [2:0] a, input logic [15:0] d);
      @(negedge clock);
      address = a;
      din     = d;
      load    = 1'b1;
      @(posedge clock);
      #1;
      load = 1'b0;
      model_mem[a] = d;
   endtask

   task automatic read_word(input logic [2:0] a, output logic [15:0] v);
      @(negedge clock);
      address = a;
      load    = 1'b0;
`ifdef RAM_REGISTERED_OUT_EN
      @(posedge clock);
      #1;
`else
      #1;
`endif
      v = dout;
   endtask

   task automatic test_reset();
      logic [15:0] v;
      reset_n = 1'b0;
      load    = 1'b0;
      din     = 16'h0000;
      address = 3'd0;
      #12;
      checks++;
      if (ready !== 1'b0) $display("FAIL reset_ready: actual %b required 0", ready);
      else passed++;
      checks++;
      if (dout !== 16'h0000) $display("FAIL reset_out: actual %h required 0000", dout);
      else passed++;
      @(negedge clock);
      reset_n = 1'b1;
      model_clear();
      for (int k = 1; k <= 8; k++) begin
         @(posedge clock);
         #1;
         checks++;
         if (ready !== (k == 8)) $display("FAIL sweep_ready edge %0d: actual %b required %b", k, ready, (k == 8));
         else passed++;
      end
      for (int a = 0; a < 8; a++) begin
         read_word(3'(a), v);
         checks++;
         if (v !== model_mem[a]) $display("FAIL cleared_read addr %0d: actual %h required %h", a, v, model_mem[a]);
         else passed++;
      end
   endtask

   task automatic test_write_read();
      logic [15:0] v;
      write_word(3'd5, 16'hBEEF);
      read_word(3'd5, v);
      checks++;
      if (v !== model_mem[5]) $display("FAIL write_read addr 5: actual %h required %h", v, model_mem[5]);
      else passed++;
      read_word(3'd4, v);
      checks++;
      if (v !== model_mem[4]) $display("FAIL neighbour addr 4: actual %h required %h", v, model_mem[4]);
      else passed++;
   endtask

   task automatic test_load_during_clear();
      logic [15:0] v;
      reset_n = 1'b0;
      #7;
      address = 3'd2;
      din     = 16'h1234;
      load    = 1'b1;
      @(negedge clock);
      reset_n = 1'b1;
      model_clear();
      repeat (5) @(posedge clock);
      #1;
      checks++;
      if (ready !== 1'b0) $display("FAIL clear_ready: actual %b required 0", ready);
      else passed++;
      checks++;
      if (dout !== 16'h0000) $display("FAIL clear_out_held: actual %h required 0000", dout);
      else passed++;
      @(negedge clock);
      load = 1'b0;
      repeat (3) @(posedge clock);
      #1;
      checks++;
      if (ready !== 1'b1) $display("FAIL clear_done_ready: actual %b required 1", ready);
      else passed++;
      read_word(3'd2, v);
      checks++;
      if (v !== model_mem[2]) $display("FAIL load_ignored addr 2: actual %h required %h", v, model_mem[2]);
      else passed++;
   endtask

   task automatic test_boundary();
      logic [15:0] v;
      write_word(3'd7, 16'hAAAA);
      write_word(3'd0, 16'h5555);
      for (int i = 0; i < 4; i++) begin
         logic [2:0] a;
         a = (i == 0) ? 3'd7 : (i == 1) ? 3'd0 : (i == 2) ? 3'd6 : 3'd1;
         read_word(a, v);
         checks++;
         if (v !== model_mem[a]) $display("FAIL boundary addr %0d: actual %h required %h", a, v, model_mem[a]);
         else passed++;
      end
   endtask

   task automatic test_reset_mid_sweep();
      logic [15:0] v;
      write_word(3'd5, 16'hBEEF);
      @(negedge clock);
      address = 3'd5;
      @(posedge clock);
      #2;
      reset_n = 1'b0;
      #1;
      checks++;
      if (ready !== 1'b0 || dout !== 16'h0000)
         $display("FAIL reset_from_ready: actual ready=%b out=%h required ready=0 out=0000", ready, dout);
      else passed++;
      @(negedge clock);
      reset_n = 1'b1;
      model_clear();
      for (int k = 1; k <= 4; k++) begin
         @(posedge clock);
         #1;
         checks++;
         if (ready !== 1'b0 || dout !== 16'h0000)
            $display("FAIL sweep_out_gated edge %0d: actual ready=%b out=%h required ready=0 out=0000", k, ready, dout);
         else passed++;
      end
      #1;
      reset_n = 1'b0;
      #1;
      checks++;
      if (ready !== 1'b0 || dout !== 16'h0000)
         $display("FAIL mid_sweep_reset: actual ready=%b out=%h required ready=0 out=0000", ready, dout);
      else passed++;
      #2;
      reset_n = 1'b1;
      for (int k = 1; k <= 8; k++) begin
         @(posedge clock);
         #1;
         checks++;
         if (ready !== (k == 8)) $display("FAIL restart_ready edge %0d: actual %b required %b", k, ready, (k == 8));
         else passed++;
      end
      read_word(3'd5, v);
      checks++;
      if (v !== model_mem[5]) $display("FAIL restart_cleared addr 5: actual %h required %h", v, model_mem[5]);
      else passed++;
   endtask

   task automatic test_same_addr_write();
      write_word(3'd3, 16'h0011);
      @(negedge clock);
      address = 3'd3;
      din     = 16'h0022;
      load    = 1'b1;
      @(posedge clock);
      #1;
      load = 1'b0;
`ifdef RAM_REGISTERED_OUT_EN
      checks++;
      if (dout !== model_mem[3]) $display("FAIL read_first: actual %h required %h", dout, model_mem[3]);
      else passed++;
      model_mem[3] = 16'h0022;
      @(posedge clock);
      #1;
      checks++;
      if (dout !== model_mem[3]) $display("FAIL read_after_write: actual %h required %h", dout, model_mem[3]);
      else passed++;
`else
      model_mem[3] = 16'h0022;
      checks++;
      if (dout !== model_mem[3]) $display("FAIL write_through: actual %h required %h", dout, model_mem[3]);
      else passed++;
`endif
   endtask

   task automatic test_random();
      logic [2:0]  a;
      logic [15:0] d;
      logic        l;
      for (int n = 0; n < 150; n++) begin
         a = 3'($urandom_range(0, 7));
         d = 16'($urandom);
         l = ($urandom_range(0, 2) == 0);
         @(negedge clock);
         address = a;
         din     = d;
         load    = l;
`ifndef RAM_REGISTERED_OUT_EN
         #1;
         checks++;
         if (dout !== model_mem[a]) $display("FAIL rand_pre iter %0d addr %0d: actual %h required %h", n, a, dout, model_mem[a]);
         else passed++;
`endif
         @(posedge clock);
         #1;
`ifdef RAM_REGISTERED_OUT_EN
         checks++;
         if (dout !== model_mem[a]) $display("FAIL rand_reg iter %0d addr %0d: actual %h required %h", n, a, dout, model_mem[a]);
         else passed++;
         if (l) model_mem[a] = d;
`else
         if (l) model_mem[a] = d;
         checks++;
         if (dout !== model_mem[a]) $display("FAIL rand_post iter %0d addr %0d: actual %h required %h", n, a, dout, model_mem[a]);
         else passed++;
`endif
         load = 1'b0;
      end
   endtask

   initial begin
      checks = 0;
      passed = 0;
      test_reset();
      test_write_read();
      test_load_during_clear();
      test_boundary();
      test_reset_mid_sweep();
      test_same_addr_write();
      test_random();
      $display("%0d/%0d checks passed", passed, checks);
      $finish;
   end

endmodule
